// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised MIPS register file.
// Depth helper, default word/address types and counter limits.
package regfile_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  localparam logic [15:0] WR_CNT_MAX = 16'hFFFF;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [WIDTH_DEF-1:0]  data_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_np_decoder_n.sv
// N-to-2^N one-hot decoder with enable.
// Unknown or unmatched addresses decode to all zeros.
module decoder_n #(
  parameter int N = 5
) (
  input  logic               en,
  input  logic [N-1:0]       a,
  output logic [(1<<N)-1:0]  y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < (1 << N); k++) begin
      if (en && (a == N'(k))) y[k] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_np.sv
// MIPS GPR file: one sync write port, N_RD async read ports.
// Register 0 is hardwired to zero; optional write-to-read bypass.
module regfile_np
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2,
  parameter int BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           wa,
  input  logic [WIDTH-1:0]            wd,
  input  logic [N_RD-1:0][ADDR_W-1:0] ra,
  output logic [N_RD-1:0][WIDTH-1:0]  rd,
  output logic [15:0]                 wr_cnt
);

  localparam int DEPTH = depth_of(ADDR_W);

  typedef logic [WIDTH-1:0] data_t;

  logic [DEPTH-1:0] wen_raw;
  logic [DEPTH-1:0] wen_onehot;
  data_t            mem_q [DEPTH];

  decoder_n #(
    .N (ADDR_W)
  ) u_wdec (
    .en (we),
    .a  (wa),
    .y  (wen_raw)
  );

  assign wen_onehot = {wen_raw[DEPTH-1:1], 1'b0};

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    data_t reg_d;
    data_t reg_q;

    always_comb begin
      reg_d = reg_q;
      if (wen_onehot[k]) reg_d = wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) reg_q <= '0;
      else        reg_q <= reg_d;
    end

    assign mem_q[k] = reg_q;
  end

  // Bypass is gated by rst_n so reads stay zero throughout reset.
  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    data_t rdat;

    always_comb begin
      rdat = '0;
      if (rst_n && (ra[i] != ADDR_W'(ZERO_REG))) begin
        if ((BYPASS != 0) && we && (wa == ra[i])) rdat = wd;
        else                                      rdat = mem_q[ra[i]];
      end
    end

    assign rd[i] = rdat;
  end

  logic [15:0] cnt_d;
  logic [15:0] cnt_q;
  logic        commit;

  assign commit = we && (wa != ADDR_W'(ZERO_REG));

  always_comb begin
    cnt_d = cnt_q;
    if (commit && (cnt_q != WR_CNT_MAX)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_np.sv
// Directed bench for regfile_np: bypass, no-bypass and small variants.
// Expectations are queued at drive time and popped at sample time.
module tb_regfile_np;

  logic clk = 1'b0;
  logic rst_n;

  logic             we;
  logic [4:0]       wa;
  logic [31:0]      wd;
  logic [1:0][4:0]  ra;
  logic [1:0][31:0] rd0;
  logic [1:0][31:0] rd1;
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;

  logic             we2;
  logic [2:0]       wa2;
  logic [15:0]      wd2;
  logic [2:0][2:0]  ra2;
  logic [2:0][15:0] rd2;
  logic [15:0]      cnt2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_np #(.WIDTH(32), .ADDR_W(5), .N_RD(2), .BYPASS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd0), .wr_cnt(cnt0)
  );

  regfile_np #(.WIDTH(32), .ADDR_W(5), .N_RD(2), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd1), .wr_cnt(cnt1)
  );

  regfile_np #(.WIDTH(16), .ADDR_W(3), .N_RD(3), .BYPASS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .we(we2), .wa(wa2), .wd(wd2),
    .ra(ra2), .rd(rd2), .wr_cnt(cnt2)
  );

  task automatic push(input string t, input logic [63:0] e);
    exp_t x;
    x.tag = t;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%h expected=<queued value>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] last;

    // Reset held, write attempted with bypass match on both ports.
    rst_n = 1'b0;
    we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; ra = {5'd7, 5'd7};
    we2 = 1'b1; wa2 = 3'd5; wd2 = 16'h1234;
    ra2 = {3'd5, 3'd5, 3'd0};
    push("rst_rd0_p0", 64'd0);
    push("rst_rd0_p1", 64'd0);
    push("rst_cnt0", 64'd0);
    push("rst_rd2", 64'd0);
    #3;
    chk(64'(rd0[0]));
    chk(64'(rd0[1]));
    chk(64'(cnt0));
    chk(64'(rd2));
    tick();
    tick();
    push("rst_hold_rd1", 64'd0);
    push("rst_hold_cnt2", 64'd0);
    chk(64'(rd1[0]));
    chk(64'(cnt2));
    rst_n = 1'b1;
    we = 1'b0;
    we2 = 1'b0;

    // Small variant: reg[5] = BEEF, ra = {5,5,0}.
    #2;
    we2 = 1'b1; wa2 = 3'd5; wd2 = 16'hBEEF;
    tick();
    we2 = 1'b0;
    ra2 = {3'd5, 3'd5, 3'd0};
    push("p_rd2", {16'h0, 16'hBEEF, 16'hBEEF, 16'h0000});
    push("p_cnt2", 64'd1);
    #1;
    chk(64'(rd2));
    chk(64'(cnt2));

    // Write sweep over k = 1..31.
    for (int k = 1; k < 32; k++) begin
      we = 1'b1; wa = 5'(k); wd = 32'hA5A50000 + 32'(k);
      tick();
    end
    we = 1'b0;
    for (int k = 1; k < 32; k++) begin
      ra = {5'(k), 5'(k)};
      push($sformatf("sw_p0_%0d", k), 64'(32'hA5A50000 + 32'(k)));
      push($sformatf("sw_p1_%0d", k), 64'(32'hA5A50000 + 32'(k)));
      push($sformatf("sw_nb_%0d", k), 64'(32'hA5A50000 + 32'(k)));
      #1;
      chk(64'(rd0[0]));
      chk(64'(rd0[1]));
      chk(64'(rd1[0]));
    end
    push("sw_cnt0", 64'd31);
    push("sw_cnt1", 64'd31);
    chk(64'(cnt0));
    chk(64'(cnt1));

    // Register zero ignores writes and is never bypassed.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
    push("z_pre", 64'd0);
    #1;
    chk(64'(rd0[0]));
    tick();
    we = 1'b0;
    push("z_post_p0", 64'd0);
    push("z_post_p1", 64'd0);
    push("z_cnt", 64'd31);
    #1;
    chk(64'(rd0[0]));
    chk(64'(rd0[1]));
    chk(64'(cnt0));

    // Bypass vs no bypass on a same-cycle write to reg 7.
    we = 1'b1; wa = 5'd7; wd = 32'h11111111;
    tick();
    wd = 32'h22222222; ra = {5'd7, 5'd7};
    push("byp_p0", 64'h22222222);
    push("byp_p1", 64'h22222222);
    push("nbyp_p0", 64'h11111111);
    push("nbyp_p1", 64'h11111111);
    #1;
    chk(64'(rd0[0]));
    chk(64'(rd0[1]));
    chk(64'(rd1[0]));
    chk(64'(rd1[1]));
    tick();
    we = 1'b0;
    push("nbyp_after", 64'h22222222);
    push("byp_after", 64'h22222222);
    push("byp_cnt", 64'd33);
    #1;
    chk(64'(rd1[0]));
    chk(64'(rd0[1]));
    chk(64'(cnt0));

    // Asynchronous reset pulse mid-cycle, then reset across a write.
    ra = {5'd3, 5'd7};
    #1;
    rst_n = 1'b0;
    push("ar_rd0", 64'd0);
    push("ar_cnt", 64'd0);
    #1;
    chk(64'(rd0[0]));
    chk(64'(cnt0));
    rst_n = 1'b1;
    push("ar_clr7", 64'd0);
    push("ar_clr3", 64'd0);
    #1;
    chk(64'(rd1[0]));
    chk(64'(rd1[1]));
    rst_n = 1'b0;
    we = 1'b1; wa = 5'd3; wd = 32'h12345678;
    tick();
    rst_n = 1'b1;
    we = 1'b0;
    push("rw_lost", 64'd0);
    push("rw_cnt", 64'd0);
    #1;
    chk(64'(rd1[1]));
    chk(64'(cnt1));

    // Counter saturation.
    last = '0;
    we = 1'b1; wa = 5'd1;
    for (int n = 0; n < 65534; n++) begin
      wd = $urandom;
      last = wd;
      tick();
    end
    push("sat_fffe", 64'h0000FFFE);
    chk(64'(cnt0));
    wd = $urandom;
    last = wd;
    tick();
    push("sat_ffff", 64'h0000FFFF);
    chk(64'(cnt0));
    wd = $urandom;
    last = wd;
    tick();
    we = 1'b0;
    ra = {5'd1, 5'd1};
    push("sat_hold0", 64'h0000FFFF);
    push("sat_hold1", 64'h0000FFFF);
    push("sat_data", 64'(last));
    #1;
    chk(64'(cnt0));
    chk(64'(cnt1));
    chk(64'(rd1[0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_np.md
# regfile_np

Parametrised MIPS general-purpose register file: 2^ADDR_W registers of WIDTH bits, one synchronous write port and N_RD asynchronous read ports. Register 0 reads as zero, and an optional write-to-read bypass is provided. It replaces the fixed 32x32 two-read-port file in the data path. The write-enable one-hot is produced by a parametrised decoder that generalises the existing 5-to-32 decoder.

## Interface
- WIDTH, 32, data width of each register.
- ADDR_W, 5, address width; the file holds DEPTH = 2^ADDR_W registers.
- N_RD, 2, number of read ports (1..4).
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  asynchronous reset, active-low; clears every register.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  WIDTH  write data.
- ra  input  N_RD x ADDR_W  read addresses, packed; port i uses ra[i].
- rd  output  N_RD x WIDTH  read data, packed; port i drives rd[i].
- wr_cnt  output  16  count of committed writes to nonzero addresses, saturating.

## Operation
- Write: on the rising edge of clk with we=1 and wa!=0, reg[wa] <= wd.
- Writes with wa=0 are discarded. They do not increment wr_cnt.
- Write decode: wen_onehot = decoder(wa) & {DEPTH{we}}. Bit 0 is forced to 0.
- Read: rd[i] is combinational from ra[i].
  - ra[i]=0 gives 0.
  - BYPASS=1 with we=1, wa=ra[i] and wa!=0 gives wd.
  - Otherwise rd[i] = reg[ra[i]].
- With BYPASS=0, a read of the address being written returns the old value until the edge.
- Several read ports may address the same register; each port returns the same value.
- wr_cnt increments by 1 per committed write and holds at 16'hFFFF.

## Timing
- Asynchronous reset: all registers and wr_cnt become 0 immediately when rst_n falls, with no clock needed.
  - While rst_n=0, every rd[i] = 0. This also holds with BYPASS=1 and we=1: the bypass is gated by rst_n.
  - Reset release is synchronous to the design: the first write commits on the first rising edge with rst_n=1.
- Write latency: 1 cycle. Data is visible on a non-bypassed read after the edge that commits it.
- Read latency: 0 cycles (combinational). Path: ra to mux to rd, plus the bypass compare.
- Reset asserted in the middle of a write cycle: the write is lost and the register stays 0.
- Read/write collision on the same edge: the read value before the edge follows the BYPASS rule; after the edge it reads wd.
- Unknown values: an X on wa while we=1 must not corrupt registers it does not decode to. The decoder emits all-zero for X or out-of-range input.

## Structure
- Package regfile_pkg holds:
  - localparam DEPTH derivation helper.
  - typedef addr_t (logic [ADDR_W-1:0]) and data_t (logic [WIDTH-1:0]) as parameterised defaults.
  - Constant ZERO_REG = 0 and WR_CNT_MAX = 16'hFFFF.
- Sub-module decoder_n: parametrised N-to-2^N one-hot decoder (parameter N = ADDR_W) with an enable input.
  - It is the direct generalisation of the existing 5-to-32 decoder.
  - It is instantiated once for the write port.
- Storage is an unpacked array of data_t with a generate loop, one always_ff per register, gated by wen_onehot[k].
- Read muxes and bypass sit in a generate loop over N_RD.

## Test plan
- Reset: drive rst_n=0 with arbitrary ra -> every rd = 0 and wr_cnt = 0. Pulse rst_n low asynchronously in the middle of a cycle -> registers clear without a clock edge.
- Write/read sweep: write wd = 32'hA5A50000 + k to k = 1..31, then read all k on both ports -> rd = 32'hA5A50000 + k. wr_cnt = 31.
- Register zero: we=1, wa=0, wd=32'hFFFFFFFF -> ra=0 reads 0 and wr_cnt is unchanged.
- Bypass: with BYPASS=1, reg[7]=32'h11111111, we=1, wa=7, wd=32'h22222222, ra[0]=ra[1]=7 -> rd[0]=rd[1]=32'h22222222 before the edge. With BYPASS=0 the same stimulus gives 32'h11111111 before the edge and 32'h22222222 after.
- Parametrisation: WIDTH=16, ADDR_W=3, N_RD=3. Write reg[5]=16'hBEEF and set ra = {5,5,0} -> rd = {16'hBEEF, 16'hBEEF, 0}. Preload wr_cnt near saturation by forcing, then write -> it holds at 16'hFFFF.
